// File: rtl/pipelined_popcount_pkg.sv
// rtl/pipelined_popcount_pkg.sv - shared widths, defaults and accumulator state for pipelined_popcount
package pipelined_popcount_pkg;

    localparam int DEF_ARRAY_LENGTH = 64;
    localparam int DEF_CHUNK_WIDTH  = 8;
    localparam int DEF_OUTPUT_SIZE  = 16;

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } acc_state_t;

    // Bits needed to hold a count of 0..n inclusive.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

    function automatic int num_chunks(input int array_length, input int chunk_width);
        return array_length / chunk_width;
    endfunction

endpackage

// File: rtl/popcount_chunk.sv
// rtl/popcount_chunk.sv - combinational set-bit count of one CHUNK_WIDTH slice
module popcount_chunk
    import pipelined_popcount_pkg::*;
#(
    parameter int CHUNK_WIDTH = DEF_CHUNK_WIDTH
) (
    input  logic [CHUNK_WIDTH-1:0]             bits,
    output logic [$clog2(CHUNK_WIDTH+1)-1:0]   count
);

    localparam int CCW = cnt_width(CHUNK_WIDTH);

    always_comb begin
        count = '0;
        for (int i = 0; i < CHUNK_WIDTH; i++) begin
            count = count + CCW'(bits[i]);
        end
    end

endmodule

// File: rtl/pipelined_popcount.sv
// rtl/pipelined_popcount.sv - three-stage backpressured popcount with per-beat and saturating frame modes
module pipelined_popcount
    import pipelined_popcount_pkg::*;
#(
    parameter int ARRAY_LENGTH = DEF_ARRAY_LENGTH,
    parameter int CHUNK_WIDTH  = DEF_CHUNK_WIDTH,
    parameter int OUTPUT_SIZE  = DEF_OUTPUT_SIZE
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic                    cfg_frame_mode,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [ARRAY_LENGTH-1:0] s_array,
    input  logic                    s_last,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [OUTPUT_SIZE-1:0]  m_count,
    output logic                    m_last,
    output logic                    m_overflow
);

    localparam int NCH = num_chunks(ARRAY_LENGTH, CHUNK_WIDTH);
    localparam int CCW = cnt_width(CHUNK_WIDTH);
    localparam int CW  = cnt_width(ARRAY_LENGTH);
    localparam int AW  = OUTPUT_SIZE + 1;

    logic rst_done;
    logic advance;
    logic accept;

    // Input is held off for the first cycle after reset release.
    assign advance = !m_valid || m_ready;
    assign s_ready = advance && rst_done;
    assign accept  = s_valid && s_ready;

    logic [NCH-1:0][CCW-1:0] chunk_cnt;
    logic [NCH-1:0][CCW-1:0] s1_cnt;
    logic                    s1_valid, s1_last, s1_mode;
    logic [CW-1:0]           tree_sum;
    logic [CW-1:0]           s2_sum;
    logic                    s2_valid, s2_last, s2_mode;

    for (genvar g = 0; g < NCH; g++) begin : g_chunk
        popcount_chunk #(.CHUNK_WIDTH(CHUNK_WIDTH)) u_chunk (
            .bits  (s_array[g*CHUNK_WIDTH +: CHUNK_WIDTH]),
            .count (chunk_cnt[g])
        );
    end

    always_comb begin
        tree_sum = '0;
        for (int i = 0; i < NCH; i++) begin
            tree_sum = tree_sum + CW'(s1_cnt[i]);
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rst_done <= 1'b0;
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            s1_mode  <= 1'b0;
            s1_cnt   <= '0;
            s2_valid <= 1'b0;
            s2_last  <= 1'b0;
            s2_mode  <= 1'b0;
            s2_sum   <= '0;
        end else begin
            rst_done <= 1'b1;
            if (advance) begin
                s1_valid <= accept;
                s1_last  <= s_last;
                s1_mode  <= cfg_frame_mode;
                s1_cnt   <= chunk_cnt;
                s2_valid <= s1_valid;
                s2_last  <= s1_last;
                s2_mode  <= s1_mode;
                s2_sum   <= tree_sum;
            end
        end
    end

    acc_state_t             state, state_next;
    logic [OUTPUT_SIZE-1:0] acc, acc_d, acc_next;
    logic                   ovf, ovf_d, ovf_next;
    logic [AW-1:0]          acc_sum;
    logic                   sat;
    logic                   frame_beat;
    logic                   emit, emit_last, emit_ovf;
    logic [OUTPUT_SIZE-1:0] emit_count;

    // RUN only exists in frame mode, so a beat arriving mid-frame is
    // accumulated regardless of the mode it carried.
    assign frame_beat = (state == ST_RUN) || s2_mode;
    assign acc_sum    = {1'b0, acc} + AW'(s2_sum);
    assign sat        = acc_sum[OUTPUT_SIZE];
    assign acc_next   = sat ? '1 : acc_sum[OUTPUT_SIZE-1:0];
    assign ovf_next   = ovf || sat;

    always_comb begin
        state_next = state;
        acc_d      = acc;
        ovf_d      = ovf;
        emit       = 1'b0;
        emit_count = OUTPUT_SIZE'(s2_sum);
        emit_last  = s2_last;
        emit_ovf   = 1'b0;
        if (advance && s2_valid) begin
            if (!frame_beat) begin
                emit = 1'b1;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (s2_last) begin
                            emit      = 1'b1;
                            emit_last = 1'b1;
                        end else begin
                            acc_d      = OUTPUT_SIZE'(s2_sum);
                            ovf_d      = 1'b0;
                            state_next = ST_RUN;
                        end
                    end
                    ST_RUN: begin
                        if (s2_last) begin
                            emit       = 1'b1;
                            emit_count = acc_next;
                            emit_last  = 1'b1;
                            emit_ovf   = ovf_next;
                            acc_d      = '0;
                            ovf_d      = 1'b0;
                            state_next = ST_IDLE;
                        end else begin
                            acc_d = acc_next;
                            ovf_d = ovf_next;
                        end
                    end
                    default: state_next = ST_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state      <= ST_IDLE;
            acc        <= '0;
            ovf        <= 1'b0;
            m_valid    <= 1'b0;
            m_count    <= '0;
            m_last     <= 1'b0;
            m_overflow <= 1'b0;
        end else begin
            state <= state_next;
            acc   <= acc_d;
            ovf   <= ovf_d;
            if (advance) begin
                m_valid <= emit;
                if (emit) begin
                    m_count    <= emit_count;
                    m_last     <= emit_last;
                    m_overflow <= emit_ovf;
                end
            end
        end
    end

endmodule

// File: tb/tb_pipelined_popcount.sv
// tb/tb_pipelined_popcount.sv - directed self-checking bench for pipelined_popcount
module tb_pipelined_popcount;

    typedef struct packed {
        logic [15:0] cnt;
        logic        last;
        logic        ovf;
    } out_t;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic        cfg_frame_mode;
    logic        s_valid;
    logic        s_ready;
    logic [63:0] s_array;
    logic        s_last;
    logic        m_valid;
    logic        m_ready;
    logic [15:0] m_count;
    logic        m_last;
    logic        m_overflow;

    logic        m7_s_ready;
    logic        m7_valid;
    logic [6:0]  m7_count;
    logic        m7_last;
    logic        m7_overflow;

    int   errors = 0;
    int   checks = 0;
    out_t oq[$];
    out_t o7q[$];
    bit   bp_mon = 0;
    bit   was_stalled = 0;
    int   stall_cnt = 0;
    logic [17:0] hold_val;
    out_t e;

    always #5 aclk = ~aclk;

    pipelined_popcount #(.ARRAY_LENGTH(64), .CHUNK_WIDTH(8), .OUTPUT_SIZE(16)) dut (
        .aclk           (aclk),
        .aresetn        (aresetn),
        .cfg_frame_mode (cfg_frame_mode),
        .s_valid        (s_valid),
        .s_ready        (s_ready),
        .s_array        (s_array),
        .s_last         (s_last),
        .m_valid        (m_valid),
        .m_ready        (m_ready),
        .m_count        (m_count),
        .m_last         (m_last),
        .m_overflow     (m_overflow)
    );

    pipelined_popcount #(.ARRAY_LENGTH(64), .CHUNK_WIDTH(8), .OUTPUT_SIZE(7)) dut7 (
        .aclk           (aclk),
        .aresetn        (aresetn),
        .cfg_frame_mode (cfg_frame_mode),
        .s_valid        (s_valid),
        .s_ready        (m7_s_ready),
        .s_array        (s_array),
        .s_last         (s_last),
        .m_valid        (m7_valid),
        .m_ready        (m_ready),
        .m_count        (m7_count),
        .m_last         (m7_last),
        .m_overflow     (m7_overflow)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic chk_entry(input string tag, input out_t x, input int cnt, input int l, input int o);
        chk({tag, "_cnt"}, 32'(x.cnt), cnt);
        chk({tag, "_last"}, 32'(x.last), l);
        chk({tag, "_ovf"}, 32'(x.ovf), o);
    endtask

    function automatic out_t pop_main();
        return (oq.size() > 0) ? oq.pop_front() : '0;
    endfunction

    function automatic out_t pop_7();
        return (o7q.size() > 0) ? o7q.pop_front() : '0;
    endfunction

    // Handshakes are recorded mid-cycle, where inputs and outputs are settled.
    always @(negedge aclk) begin
        if (aresetn && m_valid && m_ready)
            oq.push_back({m_count, m_last, m_overflow});
        if (aresetn && m7_valid && m_ready)
            o7q.push_back({9'd0, m7_count, m7_last, m7_overflow});
        if (bp_mon) begin
            if (m_valid && !m_ready) begin
                stall_cnt++;
                chk("bp_s_ready_low", 32'(s_ready), 0);
                if (was_stalled)
                    chk("bp_stable", 32'({m_count, m_last, m_overflow}), 32'(hold_val));
                hold_val    = {m_count, m_last, m_overflow};
                was_stalled = 1;
            end else begin
                was_stalled = 0;
            end
        end
    end

    task automatic send(input logic [63:0] a, input logic l, input logic md);
        bit done = 0;
        s_valid        = 1'b1;
        s_array        = a;
        s_last         = l;
        cfg_frame_mode = md;
        for (int k = 0; k < 30 && !done; k++) begin
            @(negedge aclk);
            done = s_ready;
            @(posedge aclk);
            #1;
        end
        if (!done) chk("send_timeout", 32'(s_ready), 1);
    endtask

    task automatic idle(input int n);
        s_valid = 1'b0;
        s_last  = 1'b0;
        repeat (n) begin
            @(posedge aclk);
            #1;
        end
    endtask

    initial begin
        aresetn        = 1'b0;
        cfg_frame_mode = 1'b0;
        s_valid        = 1'b0;
        s_array        = '0;
        s_last         = 1'b0;
        m_ready        = 1'b1;
        repeat (3) @(posedge aclk);
        #1;
        chk("rst_m_valid", 32'(m_valid), 0);
        chk("rst_m_count", 32'(m_count), 0);
        chk("rst_m_last", 32'(m_last), 0);
        chk("rst_m_ovf", 32'(m_overflow), 0);
        aresetn = 1'b1;
        @(posedge aclk);
        #1;
        chk("rel_s_ready", 32'(s_ready), 1);

        // Back-to-back per-beat stream, exact latency.
        s_valid = 1'b1; s_array = 64'h0; s_last = 1'b0; cfg_frame_mode = 1'b0;
        @(posedge aclk); #1;
        s_array = 64'hFFFF_FFFF_FFFF_FFFF;
        @(posedge aclk); #1;
        chk("lat_not_early", 32'(m_valid), 0);
        s_array = 64'h8000_0000_0000_0001; s_last = 1'b1;
        @(posedge aclk); #1;
        s_valid = 1'b0; s_last = 1'b0;
        chk("pb0_valid", 32'(m_valid), 1);
        chk("pb0_cnt", 32'(m_count), 0);
        chk("pb0_last", 32'(m_last), 0);
        @(posedge aclk); #1;
        chk("pb1_valid", 32'(m_valid), 1);
        chk("pb1_cnt", 32'(m_count), 64);
        @(posedge aclk); #1;
        chk("pb2_valid", 32'(m_valid), 1);
        chk("pb2_cnt", 32'(m_count), 2);
        chk("pb2_last", 32'(m_last), 1);
        @(posedge aclk); #1;
        chk("pb_drain", 32'(m_valid), 0);
        oq.delete(); o7q.delete();

        // Frame of three 8-bit beats.
        send(64'hFF, 1'b0, 1'b1);
        send(64'hFF, 1'b0, 1'b1);
        send(64'hFF, 1'b1, 1'b1);
        idle(8);
        chk("fr_outputs", oq.size(), 1);
        e = pop_main();
        chk_entry("fr", e, 24, 1, 0);
        o7q.delete();

        // Saturation in the narrow instance, then a clean frame.
        send(64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1);
        send(64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1);
        send(64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);
        send(64'h1, 1'b1, 1'b1);
        idle(8);
        chk("sat7_outputs", o7q.size(), 2);
        e = pop_7();
        chk_entry("sat7", e, 127, 1, 1);
        e = pop_7();
        chk_entry("post7", e, 1, 1, 0);
        e = pop_main();
        chk_entry("wide192", e, 192, 1, 0);
        oq.delete();

        // Backpressure during a 4-beat per-beat stream.
        bp_mon = 1;
        fork
            begin
                send(64'h3, 1'b0, 1'b0);
                send(64'hF0F0, 1'b0, 1'b0);
                send(64'hFFFF_FFFF, 1'b0, 1'b0);
                send(64'h7, 1'b0, 1'b0);
                s_valid = 1'b0;
            end
            begin
                repeat (2) begin @(posedge aclk); #1; end
                m_ready = 1'b0;
                repeat (5) begin @(posedge aclk); #1; end
                m_ready = 1'b1;
            end
        join
        idle(8);
        bp_mon = 0;
        chk("bp_stall_seen", 32'(stall_cnt > 0), 1);
        chk("bp_outputs", oq.size(), 4);
        e = pop_main(); chk("bp_0", 32'(e.cnt), 2);
        e = pop_main(); chk("bp_1", 32'(e.cnt), 8);
        e = pop_main(); chk("bp_2", 32'(e.cnt), 32);
        e = pop_main(); chk("bp_3", 32'(e.cnt), 3);
        o7q.delete();

        // Reset in the middle of a frame.
        send(64'hFFFF, 1'b0, 1'b1);
        send(64'hFFFF, 1'b0, 1'b1);
        idle(1);
        aresetn = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(m_valid), 0);
        chk("mid_rst_cnt", 32'(m_count), 0);
        chk("mid_rst_s_ready", 32'(s_ready), 0);
        repeat (2) @(posedge aclk);
        #1;
        aresetn = 1'b1;
        @(posedge aclk); #1;
        oq.delete(); o7q.delete();
        send(64'hF, 1'b1, 1'b1);
        idle(6);
        chk("post_rst_outputs", oq.size(), 1);
        e = pop_main();
        chk_entry("post_rst", e, 4, 1, 0);
        o7q.delete();

        // Mode drops to per-beat mid-frame; frame still completes.
        send(64'hFF, 1'b0, 1'b1);
        send(64'hF, 1'b0, 1'b0);
        send(64'h3, 1'b1, 1'b0);
        send(64'h1, 1'b0, 1'b0);
        send(64'h0, 1'b0, 1'b0);
        idle(8);
        chk("mode_outputs", oq.size(), 3);
        e = pop_main(); chk_entry("mode_frame", e, 14, 1, 0);
        e = pop_main(); chk_entry("mode_pb0", e, 1, 0, 0);
        e = pop_main(); chk_entry("mode_pb1", e, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipelined_popcount.md
Name: pipelined_popcount

Overview:
- Pipelined, backpressured population counter for wide bitmaps (row/column-select masks) in the relational cache datapath.
- Per beat: counts the set bits of an ARRAY_LENGTH-bit input.
- Two modes:
  - Per-beat mode: one count per beat.
  - Frame mode: beats are accumulated until s_last, then one saturating frame total is emitted.
- Sits between the mask generator and the fetch-length calculator.

Parameters:
- ARRAY_LENGTH, 64, input bitmap width; must be a multiple of CHUNK_WIDTH.
- CHUNK_WIDTH, 8, bits counted per first-stage chunk.
- OUTPUT_SIZE, 16, output count width; must be >= $clog2(ARRAY_LENGTH+1).

Ports:
- aclk  in  1  clock; all logic on the rising edge.
- aresetn  in  1  asynchronous active-low reset.
- cfg_frame_mode  in  1  0 = per-beat count, 1 = accumulate to s_last; sampled on the first beat of each frame.
- s_valid  in  1  input beat valid.
- s_ready  out  1  input beat accepted when s_valid && s_ready.
- s_array  in  ARRAY_LENGTH  bitmap to count.
- s_last  in  1  last beat of a frame; ignored in per-beat mode.
- m_valid  out  1  result valid.
- m_ready  in  1  downstream ready.
- m_count  out  OUTPUT_SIZE  count result.
- m_last  out  1  in per-beat mode, copies s_last; in frame mode, always 1.
- m_overflow  out  1  1 if the frame total saturated.

Behaviour:
- Reset: asynchronous, active-low. While asserted:
  - m_valid=0, m_count=0, m_last=0, m_overflow=0.
  - All stage valids=0, accumulator=0, FSM=IDLE.
  - s_ready=1 one cycle after release.
  - Reset mid-frame discards the partial frame; no output is emitted for it.
- Pipeline advance: advance = !m_valid || m_ready. s_ready = advance. All stages shift together when advance=1 and hold otherwise. No bubble insertion; full throughput is 1 beat/cycle.
- Stage 1 (S1): registers ARRAY_LENGTH/CHUNK_WIDTH chunk counts, each $clog2(CHUNK_WIDTH+1) wide, plus valid and last.
- Stage 2 (S2): registers the adder-tree sum of the chunk counts, width CW=$clog2(ARRAY_LENGTH+1), zero-extended; no truncation is permitted.
- Output stage:
  - Per-beat mode: m_count <= zero-extend(S2 sum), m_last <= last. Latency 3 cycles from accept to m_valid when unstalled.
  - Frame mode: uses the accumulator FSM below.
- Accumulator FSM (frame mode):
  - IDLE:
    - On an S2 beat with last=0: acc <= sum, ovf <= 0, go to RUN.
    - On an S2 beat with last=1: emit sum directly (m_valid=1, m_overflow=0), stay IDLE.
  - RUN:
    - On an S2 beat: next = acc + sum, computed at OUTPUT_SIZE+1 bits.
    - If next > 2^OUTPUT_SIZE-1: acc <= all-ones, ovf <= 1. Once saturated, acc stays saturated.
    - On last=1: emit acc-updated value with m_overflow=ovf, go to IDLE, clear acc/ovf.
  - Intermediate beats produce no m_valid.
  - Frame total latency is 3 cycles after the last beat is accepted.
- Mode sampling:
  - cfg_frame_mode is captured in S1 with each beat. The FSM latches it on a beat that starts a frame (FSM IDLE).
  - Mode changes mid-frame are ignored until the FSM returns to IDLE.
- Boundary cases:
  - All-ones input gives a count of exactly ARRAY_LENGTH.
  - All-zeros input gives 0 and still produces an output in per-beat mode.
  - A single-beat frame with s_last=1 behaves identically in both modes, except m_last=1.
  - m_count/m_last/m_overflow remain stable while m_valid && !m_ready.

Decomposition:
- Package pipelined_popcount_pkg:
  - Functions/localparams: count width CW, chunk count width, number of chunks.
  - FSM state enum {ST_IDLE, ST_RUN}.
- Sub-module popcount_chunk:
  - Parametrised CHUNK_WIDTH, purely combinational bit count.
  - Instantiated ARRAY_LENGTH/CHUNK_WIDTH times in S1.

Test Plan:
- Per-beat, back-to-back beats 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0001 with m_ready=1 -> m_count 0, 64, 2 on three consecutive cycles, first 3 cycles after first accept.
- Frame mode, 3 beats of 64'h0000_0000_0000_00FF, last on beat 3 -> single output m_count=24, m_last=1, m_overflow=0; no m_valid for beats 1-2.
- OUTPUT_SIZE=7, frame mode, 3 all-ones beats -> m_count=127, m_overflow=1; next 1-beat frame of 64'h1 -> m_count=1, m_overflow=0.
- Backpressure: m_ready=0 for 5 cycles during a 4-beat per-beat stream -> s_ready drops once m_valid=1; all 4 counts emitted in order, none lost or duplicated, outputs stable while stalled.
- aresetn asserted after beat 2 of a 4-beat frame -> outputs 0 immediately. After release, a fresh 1-beat frame of 64'hF -> m_count=4 (no residue from the aborted frame).
- cfg_frame_mode toggled 1->0 mid-frame -> current frame still accumulates to s_last; the following beats are emitted per-beat.
